// File: rtl/fpu_pkg.sv
// Shared single-precision FPU types and sizing helpers for the fadd_arb slice.
package fpu_pkg;

    typedef logic [31:0] fp32_t;

    localparam int NREQ_MAX = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fadd_p2.sv
// Pipelined IEEE-754 single-precision adder, round-to-nearest-even, subnormals kept.
// Result and overflow flag appear NSTAGE cycles after the operands are driven.
module fadd_p2
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic  clk,
    input  logic  rstn,
    input  fp32_t x1,
    input  fp32_t x2,
    output fp32_t y,
    output logic  ovf
);

    fp32_t       a, b, y_d;
    logic        ovf_d, sub, rnd_up;
    logic [9:0]  ea, eb, d, sh, e, fld;
    logic [26:0] ma, mb, mb_al, m;
    logic [53:0] al;
    logic [27:0] s;
    logic [4:0]  lz, dd;
    logic [24:0] mr;
    logic [22:0] frac;
    fp32_t       y_q [NSTAGE];
    logic        ovf_q [NSTAGE];

    always_comb begin
        // a is the larger magnitude, so the difference below never goes negative
        a     = (x1[30:0] >= x2[30:0]) ? x1 : x2;
        b     = (x1[30:0] >= x2[30:0]) ? x2 : x1;
        sub   = a[31] ^ b[31];
        ea    = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
        eb    = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
        ma    = {a[30:23] != 8'd0, a[22:0], 3'b000};
        mb    = {b[30:23] != 8'd0, b[22:0], 3'b000};
        d     = ea - eb;
        dd    = (d > 10'd27) ? 5'd27 : d[4:0];
        al    = {mb, 27'd0} >> dd;
        mb_al = al[53:27] | {26'd0, |al[26:0]};
        s     = sub ? ({1'b0, ma} - {1'b0, mb_al}) : ({1'b0, ma} + {1'b0, mb_al});
        lz    = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        if (s[27]) begin
            m  = s[27:1] | {26'd0, s[0]};
            e  = ea + 10'd1;
            sh = 10'd0;
        end else begin
            // Normalisation stops at exponent 1, leaving a subnormal if needed
            sh = ({5'd0, lz} > ea - 10'd1) ? ea - 10'd1 : {5'd0, lz};
            m  = s[26:0] << sh;
            e  = ea - sh;
        end
        rnd_up = m[2] & (m[1] | m[0] | m[3]);
        mr     = {1'b0, m[26:3]} + {24'd0, rnd_up};
        frac   = mr[24] ? mr[23:1] : mr[22:0];
        fld    = mr[24] ? e + 10'd1 : (mr[23] ? e : 10'd0);
        ovf_d  = 1'b0;
        if (a[30:23] == 8'hFF) begin
            if (a[22:0] != 23'd0 || (b[30:23] == 8'hFF && sub)) y_d = 32'h7FC0_0000;
            else y_d = a;
        end else if (fld >= 10'd255) begin
            y_d   = {a[31], 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (s == 28'd0) begin
            y_d = {a[31] & ~sub, 31'd0};
        end else begin
            y_d = {a[31], fld[7:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSTAGE; i++) begin
                y_q[i]   <= '0;
                ovf_q[i] <= 1'b0;
            end
        end else begin
            y_q[0]   <= y_d;
            ovf_q[0] <= ovf_d;
            for (int i = 1; i < NSTAGE; i++) begin
                y_q[i]   <= y_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign y   = y_q[NSTAGE-1];
    assign ovf = ovf_q[NSTAGE-1];

endmodule

// File: rtl/fadd_arb.sv
// Round-robin arbiter sharing one fadd_p2 among NREQ requesters, with result tags.
// Define FADD_ARB_PERF_EN to add the saturating issue_cnt accept counter port.
module fadd_arb
    import fpu_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NSTAGE = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_x1,
    input  logic [NREQ*32-1:0] req_x2,
    output logic [NREQ-1:0]   res_valid,
    output logic [31:0]       res_y,
    output logic              res_ovf
`ifdef FADD_ARB_PERF_EN
    ,
    output logic [31:0]       issue_cnt
`endif
);

    localparam int IDW = id_w(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d, win_id, cand;
    logic           accept;
    fp32_t          op_x1, op_x2;
    logic [NSTAGE-1:0] tag_v_q;
    logic [IDW-1:0] tag_id_q [NSTAGE];

    // An op is accepted on a rising edge where req_valid[i] & req_ready[i]; ready is a
    // combinational function of valid and ptr, and results are never back-pressured.
    always_comb begin
        accept = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!accept && req_valid[cand]) begin
                accept = 1'b1;
                win_id = cand;
            end
        end
        req_ready = accept ? (NREQ'(1) << win_id) : '0;
        op_x1     = accept ? 32'(req_x1 >> {win_id, 5'd0}) : 32'h0;
        op_x2     = accept ? 32'(req_x2 >> {win_id, 5'd0}) : 32'h0;
        ptr_d     = ptr_q;
        if (accept) ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q   <= '0;
            tag_v_q <= '0;
            for (int i = 0; i < NSTAGE; i++) tag_id_q[i] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_v_q[0]  <= accept;
            tag_id_q[0] <= win_id;
            for (int i = 1; i < NSTAGE; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign res_valid = tag_v_q[NSTAGE-1] ? (NREQ'(1) << tag_id_q[NSTAGE-1]) : '0;

    fadd_p2 #(
        .NSTAGE(NSTAGE)
    ) u_fadd (
        .clk (clk),
        .rstn(rstn),
        .x1  (op_x1),
        .x2  (op_x2),
        .y   (res_y),
        .ovf (res_ovf)
    );

`ifdef FADD_ARB_PERF_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;

    assign issue_cnt_d = (accept && issue_cnt_q != 32'hFFFF_FFFF) ? issue_cnt_q + 32'd1
                                                                  : issue_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) issue_cnt_q <= '0;
        else       issue_cnt_q <= issue_cnt_d;
    end

    assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_fadd_arb.sv
// Directed and random checks for fadd_arb: grants, result tags, latency, reset, RNE sums.
module tb_fadd_arb;

    localparam int NREQ   = 4;
    localparam int NSTAGE = 2;

    logic          clk;
    logic          rstn;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_x1;
    logic [127:0]  req_x2;
    logic [3:0]    res_valid;
    logic [31:0]   res_y;
    logic          res_ovf;
`ifdef FADD_ARB_PERF_EN
    logic [31:0]   issue_cnt;
`endif

    fadd_arb #(
        .NREQ  (NREQ),
        .NSTAGE(NSTAGE)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x1   (req_x1),
        .req_x2   (req_x2),
        .res_valid(res_valid),
        .res_y    (res_y),
        .res_ovf  (res_ovf)
`ifdef FADD_ARB_PERF_EN
        ,
        .issue_cnt(issue_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec;
    int n_err;
    int n_acc;
    int m_ptr;
    // {ovf, one-hot tag, y}, one entry per cycle, oldest retires first
    logic [36:0] exp_q[$];

    typedef struct {
        int          id;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    // Sum in double then round to single (RNE); exact for normal operands and results.
    task automatic fadd_ref(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] y, output logic ovf);
        real         r;
        logic [63:0] d;
        int          fe;
        logic [23:0] mt;
        logic        up;
        r   = f2r(a) + f2r(b);
        d   = $realtobits(r);
        ovf = 1'b0;
        if (d[62:0] == 63'd0) begin
            y = {d[63], 31'd0};
        end else begin
            fe = int'({21'd0, d[62:52]}) - 1023 + 127;
            mt = {1'b0, d[51:29]};
            up = d[28] & ((|d[27:0]) | d[29]);
            mt = mt + {23'd0, up};
            if (mt[23]) fe++;
            y = {d[63], 8'(fe), mt[22:0]};
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic [127:0] rnd_lanes();
        return {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
    endfunction

    function automatic logic [31:0] lane(input logic [127:0] bus, input int k);
        return 32'(bus >> (k * 32));
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic [3:0] v, input logic [127:0] b1, input logic [127:0] b2,
                         input logic use_ref, input logic [31:0] hy, input logic hovf);
        logic [3:0]  g;
        int          w;
        logic [1:0]  k;
        logic [31:0] ey;
        logic        eo;
        logic [36:0] e;
        req_valid = v;
        req_x1    = b1;
        req_x2    = b2;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            k = 2'((m_ptr + i) % NREQ);
            if (w < 0 && v[k]) w = int'(k);
        end
        g = (w >= 0) ? 4'(1 << w) : 4'd0;
        #1;
        chk("req_ready", 64'(req_ready), 64'(g));
        e = (exp_q.size() == NSTAGE) ? exp_q.pop_front() : 37'd0;
        chk("res_valid", 64'(res_valid), 64'(e[35:32]));
        if (e[35:32] != 4'd0) begin
            chk("res_y", 64'(res_y), 64'(e[31:0]));
            chk("res_ovf", 64'(res_ovf), 64'(e[36]));
        end
        ey = 32'd0;
        eo = 1'b0;
        if (w >= 0) begin
            if (use_ref) fadd_ref(lane(b1, w), lane(b2, w), ey, eo);
            else begin
                ey = hy;
                eo = hovf;
            end
            m_ptr = (w + 1) % NREQ;
            n_acc++;
        end
        exp_q.push_back({eo, g, ey});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 4'd0;
        #1;
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        m_ptr = 0;
        n_acc = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] b1, b2;
        logic [3:0]   mask;
        int           n_rand;
        n_vec = 0;
        n_err = 0;
        n_acc = 0;
        m_ptr = 0;
        rstn      = 1'b0;
        req_valid = 4'd0;
        req_x1    = '0;
        req_x2    = '0;

        tbl[0]  = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
        tbl[1]  = '{2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1};
        tbl[2]  = '{1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{3, 32'h4049_0FDB, 32'h3F80_0000, 32'h4084_87EE, 1'b0};
        tbl[4]  = '{0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0};
        tbl[5]  = '{1, 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001, 1'b0};
        tbl[6]  = '{2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0};
        tbl[7]  = '{3, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0};
        tbl[8]  = '{0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0};
        tbl[9]  = '{1, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 1'b0};
        tbl[10] = '{3, 32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, 1'b0};
        tbl[11] = '{2, 32'hC0A0_0000, 32'hC040_0000, 32'hC100_0000, 1'b0};

        do_reset();

        // Table: one requester per cycle, junk on the other lanes
        for (int i = 0; i < 12; i++) begin
            b1 = rnd_lanes();
            b2 = rnd_lanes();
            b1 = (b1 & ~(128'hFFFF_FFFF << (tbl[i].id * 32))) | (128'(tbl[i].x1) << (tbl[i].id * 32));
            b2 = (b2 & ~(128'hFFFF_FFFF << (tbl[i].id * 32))) | (128'(tbl[i].x2) << (tbl[i].id * 32));
            cycle(4'(1 << tbl[i].id), b1, b2, 1'b0, tbl[i].y, tbl[i].ovf);
        end
        idle(3);

        // All four requesting from reset: grants 0,1,2,3,0,1,2,3
        do_reset();
        b1 = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        b2 = {4{32'h3F80_0000}};
        for (int i = 0; i < 8; i++) cycle(4'hF, b1, b2, 1'b1, 32'd0, 1'b0);
        idle(3);

        // Move ptr to 2, then requesters 1 and 3: grant 3 first, then 1
        cycle(4'b0010, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        cycle(4'b1010, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        cycle(4'b1010, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        idle(2);

        // Single persistent requester on the top index, through the wrap
        for (int i = 0; i < 5; i++) cycle(4'b1000, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        idle(3);

        // Reset with two ops in flight: neither may retire afterwards
        do_reset();
        cycle(4'b0001, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        cycle(4'b0001, rnd_lanes(), rnd_lanes(), 1'b1, 32'd0, 1'b0);
        do_reset();
        idle(4);
`ifdef FADD_ARB_PERF_EN
        chk("issue_cnt after reset", 64'(issue_cnt), 64'd0);
`endif

        // Random operands and request masks until 10000 accepts
        do_reset();
        n_rand = 0;
        while (n_rand < 10000) begin
            mask = 4'($urandom_range(0, 15));
            b1   = rnd_lanes();
            b2   = rnd_lanes();
            if ($urandom_range(0, 15) == 0) b2 = b1 ^ {4{32'h8000_0000}};
            cycle(mask, b1, b2, 1'b1, 32'd0, 1'b0);
            if (mask != 4'd0) n_rand++;
        end
        idle(3);
`ifdef FADD_ARB_PERF_EN
        chk("issue_cnt", 64'(issue_cnt), 64'(n_acc));
`endif

        $display("%0d operations accepted in the last phase", n_acc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(10_000_000);
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/fadd_arb.md
FADD_ARB -- requirements
Module: fadd_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 SHALL have parameter NSTAGE, default 2, fadd_p2 latency in cycles from operand drive to y/ovf valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot grant, combinational; accept = req_valid & req_ready.
REQ-007 SHALL have port req_x1  input  NREQ x 32  per-requester IEEE-754 single operand 1.
REQ-008 SHALL have port req_x2  input  NREQ x 32  per-requester IEEE-754 single operand 2.
REQ-009 SHALL have port res_valid  output  NREQ  one-hot result strobe, one cycle per accepted op.
REQ-010 SHALL have port res_y  output  32  sum from shared adder; shared across requesters.
REQ-011 SHALL have port res_ovf  output  1  overflow flag from shared adder, qualified by res_valid.
REQ-012 SHALL have port issue_cnt  output  32  accepted-op counter (present only with FADD_ARB_PERF_EN).

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin: search starts at ptr, ptr <= winner+1 mod NREQ after each accept; ptr unchanged when no accept.
REQ-014 SHALL drive req_ready[i]=1 only when req_valid[i]=1 and i is the round-robin winner; no requests -> req_ready all zero.
REQ-015 SHALL drive the winner's req_x1/req_x2 to the adder in the accept cycle; no accept -> drive 32'h0 on both.
REQ-016 SHALL sustain one accept per cycle (adder never stalls; no backpressure on results).
REQ-017 SHALL carry {valid, requester id} through an NSTAGE-deep tag shift register in lockstep with the adder.
REQ-018 SHALL assert res_valid[id] exactly NSTAGE cycles after the accept edge, with res_y/res_ovf from that op.
REQ-019 SHALL preserve per-requester ordering; results return in global accept order.
REQ-020 SHALL hold res_valid all zero in cycles with no retiring op; res_y/res_ovf are don't-care then.
REQ-021 SHALL wrap ptr from NREQ-1 to 0; single persistent requester is granted every cycle.
REQ-022 SHALL treat req_x1/req_x2 changes while not granted as having no effect.

Reset
REQ-023 SHALL on rstn=0 asynchronously clear ptr to 0, all tag valids to 0, res_valid to 0, issue_cnt to 0.
REQ-024 SHALL discard in-flight operations on reset mid-operation; no res_valid for them after release.
REQ-025 SHALL allow first accept in the first cycle after rstn deasserts.

Configuration
REQ-026 SHALL, with FADD_ARB_PERF_EN defined, implement issue_cnt incrementing by 1 per accept, saturating at 32'hFFFFFFFF.
REQ-027 SHALL, without FADD_ARB_PERF_EN, omit issue_cnt port and counter logic; all other behaviour identical.

Structure
REQ-028 SHALL place fp32 word typedef, NREQ maximum and requester-id width function in shared package fpu_pkg.
REQ-029 SHALL instantiate exactly one sub-module, fadd_p2 (x1,x2,y,ovf,clk,rstn), as the shared datapath.
REQ-030 SHALL keep arbiter, tag pipeline and counter in fadd_arb itself.

Verification
REQ-031 SHALL pass: req 0 only, x1=32'h3F800000, x2=32'h40000000 -> res_valid=4'b0001 at accept+2, res_y=32'h40400000, ovf=0.
REQ-032 SHALL pass: req 2, x1=x2=32'h7F7FFFFF -> res_valid=4'b0100 at accept+2, res_y=32'h7F800000, ovf=1.
REQ-033 SHALL pass: all four req_valid held high 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; res_valid same sequence shifted 2 cycles.
REQ-034 SHALL pass: req 1 and 3 high, ptr=2 -> grant 3 first, then 1; results tagged 4'b1000 then 4'b0010.
REQ-035 SHALL pass: accept 2 ops, assert rstn=0 one cycle later -> no res_valid ever, issue_cnt=0 (PERF_EN).
REQ-036 SHALL pass: random operands, 10000 accepts, compare each res_y/res_ovf against shortreal reference and requester tag.
